time_uart_tx: RTL and testbench

//   Reads the currently selected time value (hours/mins/secs, binary) and transmits it
//   as an ASCII line "HH:MM:SS\r\n" over an 8N1 UART.
//   It is the read-out counterpart to the button/counter time-set path: it sends the

---
 rtl/time_uart_tx_pkg.sv | 77 +++++++
 rtl/time_uart_tx_if.sv | 21 ++
 rtl/time_uart_tx_byte.sv | 61 ++++++
 rtl/time_uart_tx.sv | 130 +++++++++++++
 tb/tb_time_uart_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/time_uart_tx_pkg.sv
// time_uart_tx_pkg: shared constants and helpers for the time read-out UART.
//   ASCII characters used on the line, AM/PM encodings, line lengths, the
//   line FSM state type, and the binary -> ASCII digit / byte-select helpers.
//   No ports (package).
package time_uart_tx_pkg;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_M     = 8'h4D;

    localparam logic [1:0] AP_AM = 2'b01;
    localparam logic [1:0] AP_PM = 2'b10;

    localparam int LINE_LEN_BASE = 10;   // "HH:MM:SS\r\n"
    localparam int LINE_LEN_AP   = 13;   // "HH:MM:SS XM\r\n"

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_DONE
    } line_state_t;

    // Tens digit by comparison; inputs up to 63 give 0..6.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if      (v >= 6'd60) t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    function automatic logic [7:0] ascii_tens(input logic [5:0] v);
        return ASC_ZERO + {4'b0000, tens_of(v)};
    endfunction

    function automatic logic [7:0] ascii_ones(input logic [5:0] v);
        logic [5:0] rem;
        rem = v - ({2'b00, tens_of(v)} * 6'd10);
        return ASC_ZERO + {2'b00, rem};
    endfunction

    // Character at position idx of the line. sfx selects the 13-byte form.
    function automatic logic [7:0] line_byte(input logic [3:0] idx,
                                             input logic [5:0] h,
                                             input logic [5:0] m,
                                             input logic [5:0] s,
                                             input logic [1:0] ap,
                                             input logic       sfx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = ascii_tens(h);
            4'd1:    b = ascii_ones(h);
            4'd2:    b = ASC_COLON;
            4'd3:    b = ascii_tens(m);
            4'd4:    b = ascii_ones(m);
            4'd5:    b = ASC_COLON;
            4'd6:    b = ascii_tens(s);
            4'd7:    b = ascii_ones(s);
            4'd8:    b = sfx ? ASC_SP : ASC_CR;
            4'd9:    b = sfx ? ((ap == AP_AM) ? ASC_A : ASC_P) : ASC_LF;
            4'd10:   b = ASC_M;
            4'd11:   b = ASC_CR;
            default: b = ASC_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/time_uart_tx_if.sv
// time_uart_tx_if: request/status bundle between the time source and the UART
// read-out block.
//   send              one-cycle line request
//   hours_i/mins_i/secs_i  binary time, 6 bits each
//   A_P_i             AM/PM code (only used when TIME_TX_AP_EN is defined)
//   busy, done        line status from the transmitter
// Modports: master = requester, slave = transmitter.
interface time_uart_tx_if;
    logic       send;
    logic [5:0] hours_i;
    logic [5:0] mins_i;
    logic [5:0] secs_i;
    logic [1:0] A_P_i;
    logic       busy;
    logic       done;

    modport master (output send, hours_i, mins_i, secs_i, A_P_i,
                    input  busy, done);
    modport slave  (input  send, hours_i, mins_i, secs_i, A_P_i,
                    output busy, done);
endinterface

// File: rtl/time_uart_tx_byte.sv
// time_uart_tx_byte: 8N1 byte serializer with a BIT_CYC-clock bit divider.
//   clk    system clock
//   reset  asynchronous active-low reset
//   load   accept data when ready is high; start bit appears on the next cycle
//   data   byte to send, LSB first
//   tx     UART line, idle high (registered)
//   ready  idle, or in the last cycle of the stop bit so the next byte can
//          follow with no gap
module time_uart_tx_byte #(
    parameter int BIT_CYC = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYC - 1);

    logic             active;
    logic [8:0]       shreg;      // data bits then the stop bit
    logic [3:0]       bit_left;   // bits still to show after the current one
    logic [CNT_W-1:0] baud_cnt;
    logic             last_tick;

    assign last_tick = (baud_cnt == '0);
    assign ready     = !active || (last_tick && (bit_left == 4'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            shreg    <= '1;
            bit_left <= 4'd0;
            baud_cnt <= '0;
        end else if (load && ready) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            shreg    <= {1'b1, data};
            bit_left <= 4'd9;
            baud_cnt <= CNT_MAX;
        end else if (active) begin
            if (last_tick) begin
                if (bit_left == 4'd0) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx       <= shreg[0];
                    shreg    <= {1'b1, shreg[8:1]};
                    bit_left <= bit_left - 4'd1;
                    baud_cnt <= CNT_MAX;
                end
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_uart_tx.sv
// time_uart_tx: snapshots hours/mins/secs on send and transmits the line
// "HH:MM:SS\r\n" as 8N1 UART, bytes back to back.
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    time_uart_tx_if.slave: send, hours_i, mins_i, secs_i, A_P_i in;
//          busy, done out
//   tx     UART line, idle high
// Build option: define TIME_TX_AP_EN to append " AM"/" PM" (A_P_i 01/10)
// before CR; otherwise A_P_i is ignored.
//
// state   | meaning
// IDLE    | line quiet; send snapshots inputs and loads the first byte
// LINE    | bytes in flight; next byte loaded as each stop bit ends
// DONE    | done pulse cycle; send ignored
module time_uart_tx
    import time_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    time_uart_tx_if.slave        bus,
    output logic                 tx
);
    localparam int BIT_CYC = CLK_FREQ / BAUD;

    line_state_t state;
    logic [3:0]  idx;          // bytes loaded so far in this line
    logic        busy_q;
    logic        done_q;
    logic [5:0]  snap_h, snap_m, snap_s;

    logic [5:0]  src_h, src_m, src_s;
    logic [1:0]  src_ap;
    logic        has_sfx;
    logic [3:0]  line_len;
    logic        ser_ready;
    logic        ser_load;
    logic [7:0]  ser_data;

    // In IDLE the first byte is loaded on the same edge as the snapshot,
    // so it must come straight from the inputs.
    assign src_h = (state == ST_IDLE) ? bus.hours_i : snap_h;
    assign src_m = (state == ST_IDLE) ? bus.mins_i  : snap_m;
    assign src_s = (state == ST_IDLE) ? bus.secs_i  : snap_s;

`ifdef TIME_TX_AP_EN
    logic [1:0] snap_ap;

    assign src_ap  = (state == ST_IDLE) ? bus.A_P_i : snap_ap;
    assign has_sfx = (src_ap == AP_AM) || (src_ap == AP_PM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            snap_ap <= 2'b00;
        else if (state == ST_IDLE && bus.send)
            snap_ap <= bus.A_P_i;
    end
`else
    logic unused_ap;

    assign unused_ap = ^bus.A_P_i;
    assign src_ap    = 2'b00;
    assign has_sfx   = 1'b0;
`endif

    assign line_len = has_sfx ? 4'(LINE_LEN_AP) : 4'(LINE_LEN_BASE);
    assign ser_data = line_byte(idx, src_h, src_m, src_s, src_ap, has_sfx);
    assign ser_load = ((state == ST_IDLE) && bus.send) ||
                      ((state == ST_LINE) && ser_ready && (idx != line_len));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx    <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            snap_h <= 6'd0;
            snap_m <= 6'd0;
            snap_s <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.send) begin
                        snap_h <= bus.hours_i;
                        snap_m <= bus.mins_i;
                        snap_s <= bus.secs_i;
                        idx    <= 4'd1;
                        busy_q <= 1'b1;
                        state  <= ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (ser_ready) begin
                        if (idx == line_len) begin
                            idx    <= 4'd0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    time_uart_tx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_byte (
        .clk   (clk),
        .reset (reset),
        .load  (ser_load),
        .data  (ser_data),
        .tx    (tx),
        .ready (ser_ready)
    );

endmodule

// File: tb/tb_time_uart_tx.sv
module tb_time_uart_tx;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;   // 16 clocks per bit
    localparam int L10      = 100 * B;           // 10-byte line
    localparam int L13      = 130 * B;           // 13-byte line

    logic clk;
    logic reset;
    logic tx;
    int   tests;
    int   fails;
    logic [7:0] exp_q[$];

    time_uart_tx_if bus();

    time_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Waits up to n falling edges; gives up early once reset is seen low.
    task automatic wait_cyc(input int n, inout logic ok);
        for (int i = 0; i < n; i++) begin
            if (!ok) break;
            @(negedge clk);
            if (!reset) ok = 1'b0;
        end
    endtask

    // UART receiver / scoreboard checker.
    initial begin : monitor
        logic       ok;
        logic [7:0] b;
        logic       st;
        logic       sb;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset && tx == 1'b0) begin
                ok = 1'b1;
                wait_cyc(B / 2, ok);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_cyc(B, ok);
                    b[i] = tx;
                end
                wait_cyc(B, ok);
                st = tx;
                if (ok) begin
                    check("start_bit", {31'd0, sb}, 32'd0);
                    check("stop_bit", {31'd0, st}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("line_byte", {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    end

    task automatic do_send(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                           input logic [1:0] ap, input int exp_len, input bit glitch);
        int cnt;
        bit seen;
        @(negedge clk);
        bus.hours_i = h;
        bus.mins_i  = m;
        bus.secs_i  = s;
        bus.A_P_i   = ap;
        bus.send    = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        check("busy_after_send", {31'd0, bus.busy}, 32'd1);
        check("tx_start", {31'd0, tx}, 32'd0);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 2 * exp_len + 10) begin
            @(negedge clk);
            cnt++;
            if (glitch && cnt == 300) begin
                bus.hours_i = 6'd0;
                bus.mins_i  = 6'd0;
                bus.secs_i  = 6'd0;
                bus.A_P_i   = 2'b00;
                bus.send    = 1'b1;
            end
            if (glitch && cnt == 301) bus.send = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        check("done_timing", cnt, exp_len);
        if (seen) begin
            check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            check("tx_at_done", {31'd0, tx}, 32'd1);
            bus.send = 1'b1;             // lands in the done cycle: must be ignored
            @(negedge clk);
            bus.send = 1'b0;
            check("done_one_cycle", {31'd0, bus.done}, 32'd0);
            check("send_in_done_ignored", {31'd0, bus.busy}, 32'd0);
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin : stim
        int bad;
        tests       = 0;
        fails       = 0;
        reset       = 1'b0;
        bus.send    = 1'b0;
        bus.hours_i = 6'd0;
        bus.mins_i  = 6'd0;
        bus.secs_i  = 6'd0;
        bus.A_P_i   = 2'b00;
        repeat (5) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b1;

        // 1: idle after reset
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // 2: basic line
        push_str("12:05:09\r\n");
        do_send(6'd12, 6'd5, 6'd9, 2'b00, L10, 1'b0);

        // 3: snapshot holds, mid-frame send ignored, no second line
        push_str("23:59:59\r\n");
        do_send(6'd23, 6'd59, 6'd59, 2'b00, L10, 1'b1);
        bad = 0;
        for (int i = 0; i < 2 * L10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        check("no_second_line", bad, 0);

        // 4: boundaries
        push_str("00:00:00\r\n");
        do_send(6'd0, 6'd0, 6'd0, 2'b00, L10, 1'b0);
        push_str("63:63:63\r\n");
        do_send(6'd63, 6'd63, 6'd63, 2'b00, L10, 1'b0);

        // 5: reset during byte 4
        push_str("12:3");
        @(negedge clk);
        bus.hours_i = 6'd12;
        bus.mins_i  = 6'd34;
        bus.secs_i  = 6'd56;
        bus.send    = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (4 * 10 * B + 3 * B) @(negedge clk);
        check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_done", {31'd0, bus.done}, 32'd0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        check("bytes_before_reset", exp_q.size(), 32'd0);
        push_str("01:02:03\r\n");
        do_send(6'd1, 6'd2, 6'd3, 2'b00, L10, 1'b0);

        // 6: AM/PM suffix
`ifdef TIME_TX_AP_EN
        push_str("11:30:00 PM\r\n");
        do_send(6'd11, 6'd30, 6'd0, 2'b10, L13, 1'b0);
        push_str("07:08:09 AM\r\n");
        do_send(6'd7, 6'd8, 6'd9, 2'b01, L13, 1'b0);
`else
        push_str("11:30:00\r\n");
        do_send(6'd11, 6'd30, 6'd0, 2'b10, L10, 1'b0);
`endif
        push_str("11:30:00\r\n");
        do_send(6'd11, 6'd30, 6'd0, 2'b00, L10, 1'b0);
        push_str("11:30:00\r\n");
        do_send(6'd11, 6'd30, 6'd0, 2'b11, L10, 1'b0);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
